// File: rtl/smps_pkg.sv
// Shared types for the SMPS control slice: sequencer state encodings and
// the default duty-command width.
package smps_pkg;

   localparam int DUTY_W_DEF = 8;

   typedef logic [DUTY_W_DEF-1:0] duty_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RELEASE   = 3'd1,
      ST_SOFTSTART = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4,
      ST_STOP      = 3'd5
   } seq_state_e;

endpackage

// File: rtl/ss_ramp.sv
// Soft-start/soft-stop stepper: divides period pulses by SS_DIV and offers the
// next saturating up/down duty value together with a reached-end flag.
module ss_ramp #(
   parameter int DUTY_W  = 8,
   parameter int SS_STEP = 1,
   parameter int SS_DIV  = 4
) (
   input  logic              i_clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              tick_i,
   input  logic              down_i,
   input  logic [DUTY_W-1:0] duty_i,
   input  logic [DUTY_W-1:0] target_i,
   output logic              fire_o,
   output logic [DUTY_W-1:0] duty_o,
   output logic              done_o
);

   localparam int              PW         = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(SS_DIV - 1);
   localparam logic [DUTY_W:0] STEP_X     = (DUTY_W + 1)'(SS_STEP);

   logic [PW-1:0]   presc_q;
   logic [PW-1:0]   presc_d;
   logic [DUTY_W:0] up_sum_s;

   // Prescaler advance and saturating step computation.
   always_comb begin
      fire_o   = tick_i && (presc_q == PRESC_LAST);
      up_sum_s = {1'b0, duty_i} + STEP_X;
      if (clr_i || fire_o) begin
         presc_d = '0;
      end else if (tick_i) begin
         presc_d = presc_q + 1'b1;
      end else begin
         presc_d = presc_q;
      end
      if (down_i) begin
         if ({1'b0, duty_i} > STEP_X) begin
            duty_o = duty_i - DUTY_W'(SS_STEP);
         end else begin
            duty_o = '0;
         end
         done_o = (duty_o == '0);
      end else begin
         if (up_sum_s >= {1'b0, target_i}) begin
            duty_o = target_i;
         end else begin
            duty_o = up_sum_s[DUTY_W-1:0];
         end
         done_o = (duty_o == target_i);
      end
   end

   // Prescaler register.
   always_ff @(posedge i_clk) begin
      if (!reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

// File: rtl/dpwm_sequencer.sv
// DPWM control sequencer: release, soft-start ramp, runtime retarget, latched fault.
// Optional soft stop ramp-down is built when DPWM_SEQ_SOFT_STOP_EN is defined.
module dpwm_sequencer
   import smps_pkg::*;
#(
   parameter int DUTY_W     = DUTY_W_DEF,
   parameter int DUTY_MAX   = 230,
   parameter int SS_STEP    = 1,
   parameter int SS_DIV     = 4,
   parameter int FAULT_HOLD = 16,
   parameter int RST_CYC    = 2
) (
   input  logic              i_clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              i_period_done,
   input  logic              i_fault,
   input  logic              i_cfg_valid,
   input  logic [DUTY_W-1:0] i_cfg_duty,
   output logic              o_cfg_ready,
   output logic [DUTY_W-1:0] o_duty,
   output logic              o_dpwm_en,
   output logic              o_dpwm_reset,
   output logic              o_ss_done,
   output logic              o_fault_latched,
   output logic [2:0]        o_state
);

   localparam int              HW        = $clog2(FAULT_HOLD + 1);
   localparam int              RW        = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [HW-1:0]   HOLD_MAX  = HW'(FAULT_HOLD);
   localparam logic [RW-1:0]   RCNT_LAST = RW'(RST_CYC - 1);
   localparam logic [DUTY_W-1:0] DMAX    = DUTY_W'(DUTY_MAX);
`ifdef DPWM_SEQ_SOFT_STOP_EN
   localparam seq_state_e      DISABLE_ST = ST_STOP;
`else
   localparam seq_state_e      DISABLE_ST = ST_IDLE;
`endif

   seq_state_e        state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d, duty_fsm_s;
   logic [DUTY_W-1:0] target_q, target_d;
   logic [HW-1:0]     hold_q, hold_d, hold_inc_s;
   logic [RW-1:0]     rcnt_q, rcnt_d;
   logic              en_q, en_d, dprst_q, dprst_d, ssdone_q, ssdone_d;
   logic              flt_q, flt_d, rdy_q, rdy_d;
   logic              ramp_act_s, ramp_tick_s, ramp_clr_s;
   logic              ramp_fire_s, ramp_done_s;
   logic [DUTY_W-1:0] ramp_duty_s;

   assign ramp_act_s  = (state_q == ST_SOFTSTART) || (state_q == ST_STOP);
   assign ramp_tick_s = i_period_done && ramp_act_s;
   assign ramp_clr_s  = !ramp_act_s || (state_d != state_q);

   ss_ramp #(.DUTY_W(DUTY_W), .SS_STEP(SS_STEP), .SS_DIV(SS_DIV)) u_ramp (
      .i_clk    (i_clk),
      .reset    (reset),
      .clr_i    (ramp_clr_s),
      .tick_i   (ramp_tick_s),
      .down_i   (state_q == ST_STOP),
      .duty_i   (duty_q),
      .target_i (target_q),
      .fire_o   (ramp_fire_s),
      .duty_o   (ramp_duty_s),
      .done_o   (ramp_done_s)
   );

   // Target capture with clamp; the handshake is closed while faulted.
   always_comb begin
      if (i_cfg_valid && rdy_q) begin
         target_d = (i_cfg_duty > DMAX) ? DMAX : i_cfg_duty;
      end else begin
         target_d = target_q;
      end
   end

   // Next-state and duty command; fault outranks every other condition.
   always_comb begin
      state_d    = state_q;
      duty_fsm_s = duty_q;
      rcnt_d     = '0;
      hold_d     = '0;
      hold_inc_s = (hold_q >= HOLD_MAX) ? hold_q : hold_q + 1'b1;
      case (state_q)
         ST_IDLE: begin
            state_d = (enable && !i_fault) ? ST_RELEASE : ST_IDLE;
         end
         ST_RELEASE: begin
            if (i_fault) begin
               state_d = ST_FAULT;
            end else if (!enable) begin
               state_d = ST_IDLE;
            end else if (rcnt_q == RCNT_LAST) begin
               state_d = ST_SOFTSTART;
            end else begin
               rcnt_d  = rcnt_q + 1'b1;
               state_d = ST_RELEASE;
            end
         end
         ST_SOFTSTART: begin
            if (i_fault) begin
               state_d = ST_FAULT;
            end else if (!enable) begin
               state_d = DISABLE_ST;
            end else if (i_period_done && (target_q <= duty_q)) begin
               duty_fsm_s = target_q;
               state_d    = ST_RUN;
            end else if (ramp_fire_s) begin
               duty_fsm_s = ramp_duty_s;
               state_d    = ramp_done_s ? ST_RUN : ST_SOFTSTART;
            end else begin
               state_d = ST_SOFTSTART;
            end
         end
         ST_RUN: begin
            if (i_fault) begin
               state_d = ST_FAULT;
            end else if (!enable) begin
               state_d = DISABLE_ST;
            end else if (i_period_done) begin
               duty_fsm_s = target_q;
               state_d    = ST_RUN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FAULT: begin
            hold_d = i_fault ? '0 : hold_inc_s;
            if (!i_fault && !enable && (hold_inc_s >= HOLD_MAX)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_FAULT;
            end
         end
         ST_STOP: begin
`ifdef DPWM_SEQ_SOFT_STOP_EN
            if (i_fault) begin
               state_d = ST_FAULT;
            end else if (enable) begin
               state_d = ST_SOFTSTART;
            end else if (ramp_fire_s) begin
               duty_fsm_s = ramp_duty_s;
               state_d    = ramp_done_s ? ST_IDLE : ST_STOP;
            end else begin
               state_d = ST_STOP;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Duty is forced to zero whenever the power stage is held off.
   assign duty_d = ((state_d == ST_IDLE) || (state_d == ST_RELEASE) || (state_d == ST_FAULT))
                   ? '0 : duty_fsm_s;

   // Output flags decoded from the upcoming state so they register with it.
   always_comb begin
      en_d     = 1'b0;
      dprst_d  = 1'b1;
      ssdone_d = 1'b0;
      flt_d    = 1'b0;
      rdy_d    = 1'b1;
      case (state_d)
         ST_SOFTSTART, ST_STOP: begin
            en_d    = 1'b1;
            dprst_d = 1'b0;
         end
         ST_RUN: begin
            en_d     = 1'b1;
            dprst_d  = 1'b0;
            ssdone_d = 1'b1;
         end
         ST_FAULT: begin
            flt_d = 1'b1;
            rdy_d = 1'b0;
         end
         default: begin
            en_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         duty_q   <= '0;
         target_q <= '0;
         hold_q   <= '0;
         rcnt_q   <= '0;
         en_q     <= 1'b0;
         dprst_q  <= 1'b1;
         ssdone_q <= 1'b0;
         flt_q    <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         hold_q   <= hold_d;
         rcnt_q   <= rcnt_d;
         en_q     <= en_d;
         dprst_q  <= dprst_d;
         ssdone_q <= ssdone_d;
         flt_q    <= flt_d;
         rdy_q    <= rdy_d;
      end
   end

   assign o_state         = state_q;
   assign o_duty          = duty_q;
   assign o_dpwm_en       = en_q;
   assign o_dpwm_reset    = dprst_q;
   assign o_ss_done       = ssdone_q;
   assign o_fault_latched = flt_q;
   assign o_cfg_ready     = rdy_q;

endmodule

// File: tb/tb_dpwm_sequencer.sv
// Scoreboard bench for dpwm_sequencer: a cycle model pushes expected outputs
// as stimulus is applied; they are popped and compared after each clock edge.
module tb_dpwm_sequencer;

   localparam int SS_STEP = 1;
   localparam int SS_DIV  = 4;
   localparam int HOLD    = 16;
   localparam int RSTC    = 2;
   localparam int DMAX    = 230;

   typedef struct packed {
      logic [2:0] st;
      logic [7:0] duty;
      logic [4:0] flags;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn, en, pd, flt, cv;
   logic [7:0] cd;
   logic       rdy, den, drst, ssd, fl;
   logic [7:0] duty;
   logic [2:0] st;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   m_st, m_duty, m_tgt, m_pre, m_hold, m_rc;

   always #5 clk = ~clk;

   dpwm_sequencer #(
      .DUTY_W(8), .DUTY_MAX(DMAX), .SS_STEP(SS_STEP), .SS_DIV(SS_DIV),
      .FAULT_HOLD(HOLD), .RST_CYC(RSTC)
   ) dut (
      .i_clk(clk), .reset(rstn), .enable(en), .i_period_done(pd), .i_fault(flt),
      .i_cfg_valid(cv), .i_cfg_duty(cd), .o_cfg_ready(rdy), .o_duty(duty),
      .o_dpwm_en(den), .o_dpwm_reset(drst), .o_ss_done(ssd),
      .o_fault_latched(fl), .o_state(st)
   );

   task automatic chk_eq(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_push();
      int ns, nd, np, nh, nr, nt;
      exp_t e;
      if (!rstn) begin
         ns = 0; nd = 0; nt = 0; np = 0; nh = 0; nr = 0;
      end else begin
         nt = m_tgt;
         if (cv && m_st != 4) nt = (int'(cd) > DMAX) ? DMAX : int'(cd);
         ns = m_st; nd = m_duty; np = m_pre; nh = 0; nr = 0;
         case (m_st)
            0: if (en && !flt) ns = 1;
            1: begin
               if (flt) ns = 4;
               else if (!en) ns = 0;
               else if (m_rc == RSTC - 1) ns = 2;
               else nr = m_rc + 1;
            end
            2: begin
               if (flt) ns = 4;
`ifdef DPWM_SEQ_SOFT_STOP_EN
               else if (!en) ns = 5;
`else
               else if (!en) ns = 0;
`endif
               else if (pd) begin
                  if (m_tgt <= m_duty) begin
                     nd = m_tgt; ns = 3;
                  end else begin
                     np = m_pre + 1;
                     if (np == SS_DIV) begin
                        np = 0;
                        nd = (m_duty + SS_STEP > m_tgt) ? m_tgt : m_duty + SS_STEP;
                        if (nd == m_tgt) ns = 3;
                     end
                  end
               end
            end
            3: begin
               if (flt) ns = 4;
`ifdef DPWM_SEQ_SOFT_STOP_EN
               else if (!en) ns = 5;
`else
               else if (!en) ns = 0;
`endif
               else if (pd) nd = m_tgt;
            end
            4: begin
               nh = flt ? 0 : ((m_hold + 1 > HOLD) ? HOLD : m_hold + 1);
               if (!flt && !en && nh >= HOLD) ns = 0;
            end
`ifdef DPWM_SEQ_SOFT_STOP_EN
            5: begin
               if (flt) ns = 4;
               else if (en) ns = 2;
               else if (pd) begin
                  np = m_pre + 1;
                  if (np == SS_DIV) begin
                     np = 0;
                     nd = (m_duty > SS_STEP) ? m_duty - SS_STEP : 0;
                     if (nd == 0) ns = 0;
                  end
               end
            end
`endif
            default: ns = 0;
         endcase
         if (ns != m_st) np = 0;
         if (ns == 0 || ns == 1 || ns == 4) nd = 0;
      end
      e.st    = 3'(ns);
      e.duty  = 8'(nd);
      e.flags = {ns == 2 || ns == 3 || ns == 5, ns == 0 || ns == 1 || ns == 4,
                 ns == 3, ns == 4, ns != 4};
      sb_q.push_back(e);
      m_st = ns; m_duty = nd; m_tgt = nt; m_pre = np; m_hold = nh; m_rc = nr;
   endtask

   task automatic cyc();
      exp_t e;
      model_push();
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk_eq("sb_empty", 0, 1);
      end else begin
         e = sb_q.pop_front();
         chk_eq("state", int'(st), int'(e.st));
         chk_eq("duty", int'(duty), int'(e.duty));
         chk_eq("flags", int'({den, drst, ssd, fl, rdy}), int'(e.flags));
      end
   endtask

   task automatic go_idle();
      int k = 0;
      en = 1'b0;
      while (st != 3'd0 && k < 1000) begin
         pd = ((k % 4) == 3);
         cyc();
         k++;
      end
      pd = 1'b0;
      chk_eq("go_idle", int'(st), 0);
   endtask

   initial begin
      int k, rel, ss_seen;
      rstn = 1'b0; en = 1'b0; pd = 1'b0; flt = 1'b0; cv = 1'b0; cd = 8'd0;
      m_st = 0; m_duty = 0; m_tgt = 0; m_pre = 0; m_hold = 0; m_rc = 0;

      repeat (3) cyc();
      chk_eq("rst_state", int'(st), 0);
      chk_eq("rst_outs", int'({duty, den, drst, ssd, fl}), 4);

      // Soft-start to 10 with a period pulse every 20 cycles.
      rstn = 1'b1; cv = 1'b1; cd = 8'd10; cyc(); cv = 1'b0;
      en = 1'b1; k = 0; rel = 0; ss_seen = 0;
      while (st != 3'd3 && k < 2000) begin
         pd = ((k % 20) == 19);
         cyc();
         if (st == 3'd1) rel++;
         if (ssd && ss_seen == 0) begin
            ss_seen = 1;
            chk_eq("ss_done_duty", int'(duty), 10);
         end
         k++;
      end
      pd = 1'b0;
      chk_eq("release_len", rel, RSTC);
      chk_eq("ramp_run", int'(st), 3);
      chk_eq("ramp_duty", int'(duty), 10);

      // Clamp and deferred retarget in RUN.
      cv = 1'b1; cd = 8'd250; cyc(); cv = 1'b0;
      repeat (4) cyc();
      chk_eq("hold_mid_period", int'(duty), 10);
      pd = 1'b1; cyc(); pd = 1'b0;
      chk_eq("clamp", int'(duty), 230);
      cv = 1'b1; cd = 8'd10; cyc(); cv = 1'b0;
      pd = 1'b1; cyc(); pd = 1'b0;
      chk_eq("retarget10", int'(duty), 10);

      // Disable from RUN.
      en = 1'b0; cyc();
`ifdef DPWM_SEQ_SOFT_STOP_EN
      chk_eq("disable_stop", int'(st), 5);
`else
      chk_eq("disable_idle", int'(st), 0);
`endif
      go_idle();

      // Lower retarget during soft-start.
      cv = 1'b1; cd = 8'd20; cyc(); cv = 1'b0; en = 1'b1;
      k = 0;
      while (duty != 8'd6 && k < 1000) begin
         pd = ((k % 3) == 2);
         cyc();
         k++;
      end
      pd = 1'b0;
      chk_eq("at6_state", int'(st), 2);
      cv = 1'b1; cd = 8'd3; cyc(); cv = 1'b0;
      cyc(); cyc();
      chk_eq("low_retgt_wait", int'(duty), 6);
      pd = 1'b1; cyc(); pd = 1'b0;
      chk_eq("low_retgt_duty", int'(duty), 3);
      chk_eq("low_retgt_state", int'(st), 3);

      // Fault mid-ramp with simultaneous cfg and period pulse.
      go_idle();
      cv = 1'b1; cd = 8'd50; cyc(); cv = 1'b0; en = 1'b1;
      k = 0;
      while (duty < 8'd4 && k < 1000) begin
         pd = ((k % 3) == 2);
         cyc();
         k++;
      end
      pd = 1'b0;
      chk_eq("pre_fault_state", int'(st), 2);
      flt = 1'b1; en = 1'b0; cv = 1'b1; cd = 8'd7; pd = 1'b1; cyc();
      cv = 1'b0; pd = 1'b0;
      chk_eq("fault_state", int'(st), 4);
      chk_eq("fault_outs", int'({duty, den, drst, rdy, fl}), 5);
      flt = 1'b0; repeat (15) cyc();
      flt = 1'b1; cyc();
      flt = 1'b0; repeat (15) cyc();
      chk_eq("fault_hold15", int'(st), 4);
      cyc();
      chk_eq("fault_exit", int'(st), 0);

      // Fault in IDLE is ignored but blocks start.
      flt = 1'b1; cyc(); cyc();
      en = 1'b1; cyc();
      chk_eq("idle_fault_block", int'(st), 0);
      flt = 1'b0; cyc();
      chk_eq("idle_release", int'(st), 1);

      // Ramp to RUN, then reset mid-RUN clears target.
      k = 0;
      while (st != 3'd3 && k < 500) begin
         pd = ((k % 2) == 1);
         cyc();
         k++;
      end
      pd = 1'b0;
      chk_eq("run_again_duty", int'(duty), 7);
      rstn = 1'b0; cyc(); rstn = 1'b1;
      chk_eq("midrun_rst_state", int'(st), 0);
      chk_eq("midrun_rst_outs", int'({duty, den, drst, ssd, fl}), 4);
      k = 0;
      while (st != 3'd3 && k < 200) begin
         pd = ((k % 2) == 1);
         cyc();
         k++;
      end
      pd = 1'b0;
      chk_eq("tgt_cleared_state", int'(st), 3);
      chk_eq("tgt_cleared_duty", int'(duty), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dpwm_sequencer.md
Name: dpwm_sequencer

Overview:
Control sequencer that owns the DPWM core's `enable`/`reset` and duty command.
- Performs soft-start ramp from 0 to a programmed duty target, stepping only on DPWM period boundaries.
- Accepts runtime duty retargets through a valid/ready handshake.
- Forces a latched shutdown on fault.
- Sits between the supervisory/config logic and the `dpwm` instance in the SMPS top level.

Parameters:
- DUTY_W, 8, width of duty command/target
- DUTY_MAX, 230, upper clamp applied to every accepted target
- SS_STEP, 1, duty increment per ramp step
- SS_DIV, 4, DPWM periods per ramp step (>=1)
- FAULT_HOLD, 16, consecutive fault-free clock cycles required before FAULT may exit
- RST_CYC, 2, cycles `o_dpwm_reset` is held high when starting

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  converter run request, level
- i_period_done  in  1  one-cycle pulse from DPWM at each period boundary
- i_fault  in  1  synchronous fault level (OCP/OVP), active-high
- i_cfg_valid  in  1  new duty target offered
- i_cfg_duty  in  DUTY_W  offered duty target
- o_cfg_ready  out  1  target accepted when valid&ready
- o_duty  out  DUTY_W  duty command to DPWM
- o_dpwm_en  out  1  DPWM enable
- o_dpwm_reset  out  1  DPWM reset, active-high
- o_ss_done  out  1  high while in RUN
- o_fault_latched  out  1  high while in FAULT
- o_state  out  3  current state encoding

Behaviour:
- Reset (reset==0 at clock edge):
  - state=IDLE, o_duty=0, o_dpwm_en=0, o_dpwm_reset=1.
  - o_ss_done=0, o_fault_latched=0.
  - target=0, prescaler=0, hold counter=0.
  - Reset mid-operation aborts any state identically.
- States and encodings: IDLE=0, RELEASE=1, SOFTSTART=2, RUN=3, FAULT=4, STOP=5.
- IDLE:
  - o_dpwm_reset=1, o_dpwm_en=0, o_duty=0.
  - enable&!i_fault -> RELEASE.
- RELEASE:
  - o_dpwm_reset=1 for RST_CYC cycles, then -> SOFTSTART.
  - On SOFTSTART entry: o_dpwm_reset=0, o_dpwm_en=1, o_duty=0, prescaler=0.
- SOFTSTART:
  - Each i_period_done increments the prescaler.
  - On the SS_DIV-th pulse: o_duty=min(o_duty+SS_STEP, target); prescaler=0.
  - Same cycle o_duty reaches target -> RUN.
  - target==0 -> RUN on first i_period_done.
- RUN:
  - o_ss_done=1.
  - A pending target is copied to o_duty on the next i_period_done only; o_duty never changes mid-period.
- Handshake:
  - o_cfg_ready=1 in all states except FAULT.
  - On valid&ready: target=min(i_cfg_duty, DUTY_MAX), effective next cycle.
  - Target accepted in SOFTSTART below current o_duty: o_duty=target at next i_period_done, -> RUN.
- Enable deasserted in RELEASE/SOFTSTART/RUN:
  - Without the optional feature: -> IDLE next cycle.
- Fault:
  - i_fault=1 in any state except IDLE -> FAULT next cycle, regardless of enable, cfg, or period_done (fault has highest priority).
  - In FAULT: o_duty=0, o_dpwm_en=0, o_dpwm_reset=1, o_fault_latched=1.
  - Hold counter counts consecutive cycles with i_fault=0 and clears on any i_fault=1.
  - Exit to IDLE only when hold count>=FAULT_HOLD and enable=0 (re-enable required).
  - Fault while IDLE is ignored; it blocks IDLE->RELEASE.
- i_period_done arriving outside SOFTSTART/RUN/STOP is ignored.
- All arithmetic is unsigned and saturating; no wrap of o_duty.

Optional Feature:
- Macro: DPWM_SEQ_SOFT_STOP_EN.
- With the macro defined:
  - Enable deasserted in SOFTSTART/RUN -> STOP.
  - STOP decrements o_duty by SS_STEP every SS_DIV period pulses, saturating at 0.
  - At 0 -> IDLE.
  - enable reasserted in STOP -> SOFTSTART from current o_duty.
  - Fault still overrides.
- Without the macro: STOP is unreachable and disable goes directly to IDLE.

Decomposition:
- Package smps_pkg holds:
  - state enum and its 3-bit encodings
  - DUTY_W default
  - shared duty typedef
- One sub-module, ss_ramp, is natural:
  - SS_DIV prescaler on i_period_done
  - saturating up/down stepper with a done flag
  - used by both SOFTSTART and STOP

Test Plan:
- Soft-start: reset low 3 cycles, enable=1, cfg target 10, period_done every 20 cycles -> o_dpwm_reset high 2 cycles; o_duty steps 0,1,...,10 every 4 pulses; o_ss_done rises on the step to 10.
- Clamp and retarget in RUN: cfg 250 -> target 230; o_duty stays unchanged until next period_done, then 230.
- Lower retarget in SOFTSTART: at o_duty=6, cfg 3 -> o_duty=3 at next period_done, state RUN.
- Fault mid-ramp: i_fault=1 with simultaneous cfg_valid and period_done -> next cycle o_duty=0, o_dpwm_en=0, state 4, cfg_ready=0.
  - Fault low 15 cycles then high, then low 16 cycles with enable=0 -> IDLE only after the full 16-cycle run.
- Disable: enable=0 in RUN -> IDLE next cycle without the macro.
  - With DPWM_SEQ_SOFT_STOP_EN: o_duty ramps 10->0 one step per 4 pulses, then IDLE.
- Reset mid-RUN: reset low one edge -> all outputs at reset values on that edge; target cleared.
